// File: rtl/falafel_pkg.sv
// falafel_pkg: shared widths, limits and the tagged response type for the falafel response path.
package falafel_pkg;
  localparam int MSG_ID_SIZE = 8;
  localparam int DATA_W = 32;
  localparam int MAX_RESP_CHANNELS = 16;
  localparam int DROP_CNT_W = 16;
  typedef struct packed {
    logic [MSG_ID_SIZE-1:0] msg_id;
    logic [DATA_W-1:0]      data;
  } resp_msg_t;
endpackage

// File: rtl/falafel_fifo.sv
// falafel_fifo: registered-output-free circular FIFO with wrap-bit pointers and an occupancy count.
module falafel_fifo #(
  parameter int DATA_W = 8,
  parameter int NUM_ENTRIES = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               push_i,
  input  logic [DATA_W-1:0]                  data_i,
  input  logic                               pop_i,
  output logic [DATA_W-1:0]                  data_o,
  output logic                               full_o,
  output logic                               empty_o,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   count_o
);
  localparam int PW = $clog2(NUM_ENTRIES);
  logic [PW:0]       wr_q, wr_d, rd_q, rd_d;
  logic [DATA_W-1:0] mem_q [NUM_ENTRIES];
  logic              do_push, do_pop;
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign empty_o = wr_q == rd_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign wr_d    = wr_q + (PW+1)'(do_push);
  assign rd_d    = rd_q + (PW+1)'(do_pop);
  assign data_o  = mem_q[rd_q[PW-1:0]];
  assign count_o = wr_q - rd_q;
  // Storage is cleared on reset so the head outputs read zero until the first push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (do_push) mem_q[wr_q[PW-1:0]] <= data_i;
    end
  end
endmodule

// File: rtl/falafel_resp_router.sv
// falafel_resp_router: demultiplexes tagged responses by message ID into per-requester queues,
// discarding and counting responses whose ID selects a nonexistent channel.
module falafel_resp_router
  import falafel_pkg::*;
#(
  parameter int NUM_CHANNELS = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = DROP_CNT_W
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      in_val_i,
  output logic                                      in_rdy_o,
  input  logic [MSG_ID_SIZE-1:0]                    in_id_i,
  input  logic [DATA_W-1:0]                         in_data_i,
  output logic [NUM_CHANNELS-1:0]                   rsp_val_o,
  input  logic [NUM_CHANNELS-1:0]                   rsp_rdy_i,
  output logic [NUM_CHANNELS*DATA_W-1:0]            rsp_data_o,
  output logic [NUM_CHANNELS*MSG_ID_SIZE-1:0]       rsp_id_o,
  output logic [NUM_CHANNELS*$clog2(DEPTH+1)-1:0]   occupancy_o,
  output logic                                      drop_pulse_o,
  output logic [CNT_W-1:0]                          drop_cnt_o
);
  localparam int CH_W = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  localparam int OW = $clog2(DEPTH+1);
  if (NUM_CHANNELS < 1 || NUM_CHANNELS > MAX_RESP_CHANNELS) begin : g_bad_cfg
    $error("falafel_resp_router: NUM_CHANNELS out of range");
  end
  logic [CH_W-1:0]          ch;
  logic                     ch_ok, xfer;
  logic [NUM_CHANNELS-1:0]  full, empty, push;
  logic [(1<<CH_W)-1:0]     full_x;
  logic                     drop_q, drop_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  resp_msg_t                in_msg;
  assign ch     = in_id_i[CH_W-1:0];
  assign ch_ok  = int'(ch) < NUM_CHANNELS;
  // Unused select codes read as full so indexing never leaves the vector; ch_ok masks them.
  always_comb begin
    full_x = '1;
    full_x[NUM_CHANNELS-1:0] = full;
  end
  assign in_rdy_o = rst_ni && (!ch_ok || !full_x[ch]);
  assign xfer     = in_val_i && in_rdy_o;
  assign in_msg   = '{msg_id: in_id_i, data: in_data_i};
  assign drop_d   = xfer && !ch_ok;
  assign cnt_d    = (drop_d && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
    end
  end
  assign drop_pulse_o = drop_q;
  assign drop_cnt_o   = cnt_q;
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    resp_msg_t head;
    assign push[c] = xfer && int'(ch) == c;
    falafel_fifo #(
      .DATA_W($bits(resp_msg_t)),
      .NUM_ENTRIES(DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push[c]),
      .data_i  (in_msg),
      .pop_i   (rsp_val_o[c] && rsp_rdy_i[c]),
      .data_o  (head),
      .full_o  (full[c]),
      .empty_o (empty[c]),
      .count_o (occupancy_o[c*OW +: OW])
    );
    assign rsp_val_o[c] = !empty[c];
    assign rsp_data_o[c*DATA_W +: DATA_W] = head.data;
    assign rsp_id_o[c*MSG_ID_SIZE +: MSG_ID_SIZE] = head.msg_id;
  end
endmodule
